// File: rtl/oled_spi_arb.sv
// Round-robin arbiter sharing one byte-level SPI master between two OLED requesters,
// with locked multi-byte bursts and the spi_en/spi_fin handshake.
module oled_spi_arb #(
  parameter int unsigned LOCK_MAX = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       dc0,
  input  logic       dc1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       spi_en,
  output logic [7:0] spi_data,
  output logic       dc,
  input  logic       spi_fin
);

  localparam int unsigned CW = $clog2(LOCK_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]    state;
  logic          owner;
  logic          last;
  logic          lk;
  logic [CW-1:0] hold_cnt;

  logic       win;
  logic       sel;
  logic       req_w;
  logic       lock_w;
  logic [7:0] sel_data;
  logic       sel_dc;

  // In IDLE the capture source is the arbitration winner; afterwards it is the current owner.
  always_comb begin
    win      = (req0 & req1) ? ~last : req1;
    sel      = (state == ST_IDLE) ? win : owner;
    req_w    = owner ? req1 : req0;
    lock_w   = owner ? lock1 : lock0;
    sel_data = sel ? data1 : data0;
    sel_dc   = sel ? dc1 : dc0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      lk       <= 1'b0;
      hold_cnt <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      spi_en   <= 1'b0;
      spi_data <= '0;
      dc       <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 | req1) begin
            owner    <= win;
            gnt0     <= ~win;
            gnt1     <= win;
            spi_data <= sel_data;
            dc       <= sel_dc;
            spi_en   <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (spi_fin) begin
            spi_en <= 1'b0;
            done0  <= ~owner;
            done1  <= owner;
            lk     <= lock_w;
            state  <= ST_DRAIN;
          end
        end
        // Waiting for spi_fin low guarantees spi_ctrl is idle before any new byte starts.
        ST_DRAIN: begin
          if (!spi_fin) begin
            if (!lk) begin
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
              last  <= owner;
              state <= ST_IDLE;
            end else if (req_w) begin
              spi_data <= sel_data;
              dc       <= sel_dc;
              spi_en   <= 1'b1;
              state    <= ST_SEND;
            end else begin
              hold_cnt <= '0;
              state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (req_w) begin
            spi_data <= sel_data;
            dc       <= sel_dc;
            spi_en   <= 1'b1;
            state    <= ST_SEND;
          end else if (!lock_w || hold_cnt == CW'(LOCK_MAX - 1)) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            last  <= owner;
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          spi_en   <= 1'b0;
          spi_data <= '0;
          dc       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_arb.sv
// Bench for oled_spi_arb: vector table, directed corner sequences, and a randomized
// two-requester run checked against a transaction-level scoreboard.
module tb_oled_spi_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_v;
  logic [1:0] lock_v;
  logic [1:0] dc_v;
  logic [7:0] data_v [2];
  logic       gnt0, gnt1, done0, done1, spi_en, dc, spi_fin;
  logic [7:0] spi_data;

  always #5 clk = ~clk;

  oled_spi_arb #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req_v[0]), .req1(req_v[1]),
    .lock0(lock_v[0]), .lock1(lock_v[1]),
    .data0(data_v[0]), .data1(data_v[1]),
    .dc0(dc_v[0]), .dc1(dc_v[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .spi_en(spi_en), .spi_data(spi_data), .dc(dc), .spi_fin(spi_fin)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // spi_ctrl stand-in: raises spi_fin fin_len cycles into a byte, drops it fin_extra cycles after spi_en falls.
  int fin_len = 8;
  int fin_extra = 0;
  int fin_cnt = 0;
  bit rand_fin = 0;
  initial begin
    spi_fin = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        spi_fin = 1'b0;
        fin_cnt = 0;
      end else if (spi_en && !spi_fin) begin
        if (fin_cnt >= fin_len - 1) begin spi_fin = 1'b1; fin_cnt = 0; end
        else fin_cnt++;
      end else if (!spi_en && spi_fin) begin
        if (fin_cnt >= fin_extra) begin
          spi_fin = 1'b0;
          fin_cnt = 0;
          if (rand_fin) begin
            fin_len = $urandom_range(1, 6);
            fin_extra = $urandom_range(0, 2);
          end
        end else fin_cnt++;
      end
    end
  end

  function automatic logic cond(input int which);
    case (which)
      0: return spi_en;
      1: return done0;
      2: return done1;
      3: return !gnt0 && !gnt1;
      default: return !spi_fin;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int maxc);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!cond(which) && k < maxc);
    chk(name, 32'(cond(which)), 32'd1);
  endtask

  // Scoreboard: per-requester byte order, burst contiguity, round-robin, handshake invariants.
  typedef struct packed {
    logic       more;
    logic       c;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  bit         mon_en = 0;
  logic [1:0] p_gnt;
  logic       p_en, p_done0, p_done1, p_dc, lock_pending, lock_owner, last_rel, own, exp_w;
  logic [7:0] p_data;
  exp_t       e;
  int         sz;

  initial begin
    p_gnt = '0; p_en = 0; p_done0 = 0; p_done1 = 0; p_dc = 0; p_data = '0;
    lock_pending = 0; lock_owner = 0; last_rel = 1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        last_rel = 1'b1; p_gnt = '0; p_en = 0; p_done0 = 0; p_done1 = 0; lock_pending = 0;
      end else begin
        if (mon_en) begin
          chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
          if (spi_en && !p_en) begin
            own = gnt1;
            chk("en_has_gnt", 32'(gnt0 | gnt1), 32'd1);
            if (lock_pending) chk("burst_owner", 32'(own), 32'(lock_owner));
            sz = own ? exp_q1.size() : exp_q0.size();
            chk("byte_expected", 32'(sz > 0), 32'd1);
            if (sz > 0) begin
              e = own ? exp_q1.pop_front() : exp_q0.pop_front();
              chk("rand_data", 32'(spi_data), 32'(e.d));
              chk("rand_dc", 32'(dc), 32'(e.c));
              lock_pending = e.more;
              lock_owner = own;
            end
          end
          if (p_gnt == 2'b00 && (gnt0 | gnt1)) begin
            exp_w = (req_v == 2'b11) ? ~last_rel : req_v[1];
            chk("rr_winner", 32'(gnt1), 32'(exp_w));
          end
          if (p_en && spi_en) begin
            chk("data_stable", 32'(spi_data), 32'(p_data));
            chk("dc_stable", 32'(dc), 32'(p_dc));
          end
          if (done0) begin
            chk("done0_pulse", 32'(p_done0), 32'd0);
            chk("done0_gnt", 32'(gnt0), 32'd1);
          end
          if (done1) begin
            chk("done1_pulse", 32'(p_done1), 32'd0);
            chk("done1_gnt", 32'(gnt1), 32'd1);
          end
        end
        if (p_gnt != 2'b00 && !(gnt0 | gnt1)) last_rel = p_gnt[1];
        p_gnt = {gnt1, gnt0}; p_en = spi_en; p_done0 = done0; p_done1 = done1;
        p_data = spi_data; p_dc = dc;
      end
    end
  end

  task automatic requester(input int id, input int nbursts);
    int len, k;
    logic [7:0] d;
    logic c;
    exp_t x;
    for (int b = 0; b < nbursts; b++) begin
      len = $urandom_range(1, 3);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) begin
          req_v[id] = 1'b0;
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        d = 8'($urandom);
        c = 1'($urandom);
        x.more = (i < len - 1);
        x.c = c;
        x.d = d;
        if (id == 0) exp_q0.push_back(x); else exp_q1.push_back(x);
        data_v[id] = d;
        dc_v[id] = c;
        lock_v[id] = (i < len - 1);
        req_v[id] = 1'b1;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!(id == 1 ? done1 : done0) && k < 400);
        chk($sformatf("rand_done%0d", id), 32'(id == 1 ? done1 : done0), 32'd1);
      end
      req_v[id] = 1'b0;
      lock_v[id] = 1'b0;
    end
  endtask

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       c0, c1;
    logic [1:0] eg;
    logic [7:0] ed;
    logic       ec;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int cnt;
    rst = 1'b1; req_v = '0; lock_v = '0; dc_v = '0; data_v[0] = '0; data_v[1] = '0;

    tbl[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 2'b01, 8'h11, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'hAE, 1'b0, 1'b0, 2'b10, 8'hAE, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 2'b01, 8'h33, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b1, 2'b10, 8'h66, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 2'b01, 8'h77, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 8'h88, 8'h00, 1'b0, 1'b1, 2'b01, 8'h88, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h99, 8'hA5, 1'b0, 1'b1, 2'b10, 8'hA5, 1'b1};

    repeat (2) @(posedge clk); #1;
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_done", 32'({done1, done0}), 32'd0);
    chk("rst_en", 32'(spi_en), 32'd0);
    chk("rst_data", 32'(spi_data), 32'd0);
    chk("rst_dc", 32'(dc), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Asynchronous reset in the middle of a byte
    fin_len = 20;
    @(negedge clk); data_v[1] = 8'h5A; dc_v[1] = 1'b1; req_v[1] = 1'b1;
    @(posedge clk); #1;
    chk("mid_en", 32'(spi_en), 32'd1);
    chk("mid_data", 32'(spi_data), 32'h5A);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("arst_en", 32'(spi_en), 32'd0);
    chk("arst_data", 32'(spi_data), 32'd0);
    chk("arst_dc", 32'(dc), 32'd0);
    req_v = '0;
    @(negedge clk); rst = 1'b0;
    fin_len = 8;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      data_v[0] = tbl[i].d0; data_v[1] = tbl[i].d1;
      dc_v = {tbl[i].c1, tbl[i].c0};
      req_v = {tbl[i].r1, tbl[i].r0};
      @(posedge clk); #1;
      chk($sformatf("vec%0d_gnt", i), 32'({gnt1, gnt0}), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_en", i), 32'(spi_en), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(spi_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_dc", i), 32'(dc), 32'(tbl[i].ec));
      wait_for($sformatf("vec%0d_done", i), tbl[i].eg[1] ? 2 : 1, 50);
      @(negedge clk); req_v = '0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_len", i), 32'({done1, done0}), 32'd0);
      wait_for($sformatf("vec%0d_release", i), 3, 20);
      chk($sformatf("vec%0d_fin_low", i), 32'(spi_fin), 32'd0);
    end

    // Both requesters held continuously: grants must alternate
    @(negedge clk); data_v[0] = 8'hA0; data_v[1] = 8'hB1; dc_v = 2'b10; req_v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_for("rr_en", 0, 40);
      chk($sformatf("rr%0d_owner", i), 32'(gnt1), 32'(i % 2));
      chk($sformatf("rr%0d_excl", i), 32'(gnt0 & gnt1), 32'd0);
      chk($sformatf("rr%0d_data", i), 32'(spi_data), (i % 2 == 1) ? 32'hB1 : 32'hA0);
      wait_for("rr_done", (i % 2 == 1) ? 2 : 1, 40);
    end
    @(negedge clk); req_v = '0;
    wait_for("rr_release", 3, 20);

    // Locked command/argument pair while requester 1 waits
    @(negedge clk);
    data_v[0] = 8'h8D; dc_v = 2'b00; lock_v = 2'b01; data_v[1] = 8'h5C; req_v = 2'b11;
    @(posedge clk); #1;
    chk("lock_first_gnt", 32'({gnt1, gnt0}), 32'b01);
    chk("lock_first_data", 32'(spi_data), 32'h8D);
    wait_for("lock_done_a", 1, 40);
    @(negedge clk); data_v[0] = 8'h14; lock_v = 2'b00;
    @(posedge clk); #1;
    chk("lock_b2b_en", 32'(spi_en), 32'd1);
    chk("lock_second_gnt", 32'({gnt1, gnt0}), 32'b01);
    chk("lock_second_data", 32'(spi_data), 32'h14);
    wait_for("lock_done_b", 1, 40);
    @(negedge clk); req_v[0] = 1'b0;
    wait_for("lock_then_1", 0, 20);
    chk("lock_then_gnt1", 32'({gnt1, gnt0}), 32'b10);
    chk("lock_then_data", 32'(spi_data), 32'h5C);
    wait_for("lock_done1", 2, 40);
    @(negedge clk); req_v = '0;
    wait_for("lock_release", 3, 20);

    // Lock held with no further request: forced release after LOCK_MAX cycles of HOLD
    @(negedge clk);
    data_v[0] = 8'hC1; data_v[1] = 8'hD2; dc_v = 2'b01; lock_v = 2'b01; req_v = 2'b11;
    wait_for("to_done0", 1, 40);
    @(negedge clk); req_v[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("to_hold%0d_gnt", k), 32'({gnt1, gnt0}), 32'b01);
      chk($sformatf("to_hold%0d_en", k), 32'(spi_en), 32'd0);
    end
    @(posedge clk); #1;
    chk("to_released", 32'({gnt1, gnt0}), 32'b00);
    @(posedge clk); #1;
    chk("to_gnt1", 32'({gnt1, gnt0}), 32'b10);
    chk("to_gnt1_en", 32'(spi_en), 32'd1);
    chk("to_gnt1_data", 32'(spi_data), 32'hD2);
    chk("to_gnt1_dc", 32'(dc), 32'd0);
    lock_v = '0;
    wait_for("to_done1", 2, 40);
    @(negedge clk); req_v = '0;
    wait_for("to_release", 3, 20);

    // spi_fin lingering after spi_en drops must block the next byte
    fin_extra = 5;
    @(negedge clk);
    data_v[0] = 8'hE7; data_v[1] = 8'hF8; dc_v = 2'b01; req_v = 2'b11;
    @(posedge clk); #1;
    chk("hs_gnt0", 32'({gnt1, gnt0}), 32'b01);
    wait_for("hs_done0", 1, 40);
    @(negedge clk); req_v[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!spi_fin) break;
      chk("hs_en_low", 32'(spi_en), 32'd0);
      chk("hs_data_held", 32'(spi_data), 32'hE7);
      chk("hs_dc_held", 32'(dc), 32'd1);
      cnt++;
    end
    chk("hs_fin_cycles", 32'(cnt >= 5), 32'd1);
    fin_extra = 0;
    wait_for("hs_next_en", 0, 20);
    chk("hs_next_gnt", 32'({gnt1, gnt0}), 32'b10);
    chk("hs_next_data", 32'(spi_data), 32'hF8);
    chk("hs_next_dc", 32'(dc), 32'd0);
    wait_for("hs_done1", 2, 40);
    @(negedge clk); req_v = '0;
    wait_for("hs_release", 3, 20);

    // Randomized traffic from both requesters
    @(negedge clk);
    rand_fin = 1;
    mon_en = 1;
    fork
      requester(0, 12);
      requester(1, 12);
    join
    repeat (20) @(posedge clk);
    #1;
    mon_en = 0;
    chk("rand_q0_empty", 32'(exp_q0.size()), 32'd0);
    chk("rand_q1_empty", 32'(exp_q1.size()), 32'd0);
    chk("rand_idle", 32'({gnt1, gnt0, spi_en}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/oled_spi_arb.md
# oled_spi_arb

Two-requester arbiter that shares the single byte-level `spi_ctrl` master between the OLED init sequencer and the display-data writer. It performs round-robin arbitration, muxes byte and D/C onto the SPI master, and runs the `spi_en`/`spi_fin` handshake. It also supports locked multi-byte bursts so command/argument pairs are never interleaved. It sits between the OLED requesters and `spi_ctrl` inside the OLED top level.

## Interface
- `LOCK_MAX`, default 1024: maximum idle cycles a locked grant is held with no request before forced release (≥2).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0`, `req1` in 1: byte request from requester 0/1; held high until matching `done` pulse.
- `lock0`, `lock1` in 1: keep grant after current byte (burst).
- `data0`, `data1` in 8: byte to send; sampled at capture only.
- `dc0`, `dc1` in 1: D/C level for that byte (0 = command, 1 = data).
- `gnt0`, `gnt1` out 1: grant to requester; at most one high.
- `done0`, `done1` out 1: one-cycle pulse when that requester's byte has been shifted out.
- `spi_en` out 1: to `spi_ctrl`; high during a byte transfer.
- `spi_data` out 8: to `spi_ctrl`; stable while `spi_en` high.
- `dc` out 1: D/C to panel; stable for the entire transfer.
- `spi_fin` in 1: from `spi_ctrl`; high when byte is complete, low again after `spi_en` drops.

## Operation
- Registers: `state`, `owner` (0/1), `last` (last released owner), `hold_cnt`.
- `last` resets to 1, so requester 0 wins the first tie.
- **IDLE**
  - With no `req`, stay in IDLE; `gnt` = 00.
  - With a request, pick the winner `w`. A single requester wins. When both request, `w` = !`last`.
  - Capture: `owner`<=w, `gnt_w`<=1, `spi_data`<=data_w, `dc`<=dc_w, `spi_en`<=1, go to SEND.
- **SEND**
  - Wait for `spi_fin`=1.
  - Then `spi_en`<=0, `done_w`<=1 for one cycle, sample `lock_w` into `lk`, go to DRAIN.
- **DRAIN**
  - Wait for `spi_fin`=0, which guarantees `spi_ctrl` is back in idle.
  - If `lk`=0: `gnt`<=00, `last`<=owner, go to IDLE.
  - If `lk`=1 and `req_w`=1: capture the next byte from the owner (as in IDLE), go to SEND.
  - If `lk`=1 and `req_w`=0: `hold_cnt`<=0, go to HOLD.
- **HOLD** (grant retained, `spi_en` low)
  - Priority 1: `req_w`=1 → capture, go to SEND.
  - Priority 2: `lock_w`=0 → release (`gnt`<=00, `last`<=owner), go to IDLE.
  - Priority 3: `hold_cnt`=LOCK_MAX-1 → forced release, go to IDLE.
  - Otherwise `hold_cnt`++.
- Requests from the non-owner are ignored until release; that requester waits with `req` held.
- Requester protocol:
  - Once `req` is raised, keep it high until `done`.
  - `data`/`dc` need only be valid in the cycle `gnt` rises, or, during a burst, whenever `req` is high.
  - `req` dropped before capture is simply not served.
- A requester dropping `lock` while in SEND/DRAIN takes effect only via the `lk` sample taken at `done`.
- `dc` holds its last value when idle; `spi_data` likewise.
- Illegal/unused state encodings go to IDLE with all outputs cleared.

## Timing
- Reset values: `gnt0`=`gnt1`=0, `done0`=`done1`=0, `spi_en`=0, `spi_data`=8'h00, `dc`=0; state IDLE, `last`=1, `hold_cnt`=0.
- Reset mid-transfer: everything returns to these values immediately. `spi_ctrl` shares `rst`, so no byte is resumed.
- Request to `spi_en` latency: `req` high at edge N (state IDLE) → `gnt` and `spi_en` high after edge N+1.
- `spi_fin` high sampled at edge M → `spi_en` low and `done` high after M+1; `done` low after M+2.
- Back-to-back locked burst: next `spi_en` rises 1 cycle after `spi_fin` is first sampled low in DRAIN.
- Unlocked release to a new grant: release edge enters IDLE; the waiting requester's `gnt` rises at the next edge. Minimum gap is 2 cycles of `spi_en` low between different owners.
- `spi_data`/`dc` change only on capture edges, never while `spi_en`=1.

## Test plan
- **Reset defaults:** assert `rst` asynchronously mid-SEND → all outputs 0 within the same cycle, state IDLE; after release, `req0`=`req1`=1 simultaneously → `gnt0` wins.
- **Single byte:** `req1`, `data1`=8'hAE, `dc1`=0, `spi_fin` model 8 cycles → `spi_en` 1 cycle after `req1`, `spi_data`=AE, `done1` pulses once, `gnt1` drops after `spi_fin` low.
- **Round-robin:** both requests held continuously, unlocked → grants alternate 0,1,0,1 for 4 bytes; `gnt` is never 11.
- **Locked pair:** `req0`+`lock0` with 8'h8D then 8'h14 while `req1` pending → both requester-0 bytes sent consecutively, then `gnt1`.
- **Lock timeout:** `LOCK_MAX`=4, `lock0` held, `req0` low after the first byte → `gnt0` released exactly 4 cycles after entering HOLD; `req1` is then served.
- **Handshake safety:** hold `spi_fin` high 5 cycles after `spi_en` drops → no new `spi_en` until `spi_fin` is low, with `dc`/`spi_data` unchanged throughout.
